// File: rtl/isc_issue_ctrl.sv
// Issue controller: RID scoreboard with RAW/WAW stall, single registered
// output stage shared by ARITH/MEM/PBS, per-unit credit counters, and a
// SYNC drain barrier.

// Outstanding-instruction counter for one execution unit.
module isc_cred_cnt (
  input  logic       clk,
  input  logic       s_rst,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o,
  output logic       err_o
);
  logic [3:0] cnt_q, cnt_d;

  // +1 on issue handshake, -1 on ack, both together cancel; ack at 0 holds 0.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)                        cnt_d = cnt_q + 4'd1;
    else if (dec_i && !inc_i && cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (s_rst) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign err_o = dec_i && (cnt_q == 4'd0);
endmodule

module isc_issue_ctrl #(
  parameter int RID_NB   = 64,
  parameter int RID_W    = $clog2(RID_NB),
  parameter int CID_W    = 16,
  parameter int CRED_MAX = 8
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [2:0]       in_kind,
  input  logic [RID_W-1:0] in_dst_rid,
  input  logic [RID_W-1:0] in_dst_mask,
  input  logic [CID_W-1:0] in_cid,
  input  logic             in_srca_vld,
  input  logic [RID_W-1:0] in_srca_rid,
  input  logic             in_srcb_vld,
  input  logic [RID_W-1:0] in_srcb_rid,
  input  logic             in_flush,
  output logic             arith_vld,
  output logic             mem_vld,
  output logic             pbs_vld,
  input  logic             arith_rdy,
  input  logic             mem_rdy,
  input  logic             pbs_rdy,
  output logic [2:0]       out_kind,
  output logic [RID_W-1:0] out_dst_rid,
  output logic [RID_W-1:0] out_dst_mask,
  output logic [CID_W-1:0] out_cid,
  output logic [RID_W-1:0] out_srca_rid,
  output logic [RID_W-1:0] out_srcb_rid,
  output logic             out_flush,
  input  logic             arith_ack,
  input  logic             mem_ack,
  input  logic             pbs_ack,
  input  logic [RID_W-1:0] arith_ack_rid,
  input  logic [RID_W-1:0] mem_ack_rid,
  input  logic [RID_W-1:0] pbs_ack_rid,
  input  logic [RID_W-1:0] arith_ack_mask,
  input  logic [RID_W-1:0] mem_ack_mask,
  input  logic [RID_W-1:0] pbs_ack_mask,
  input  logic             mem_ack_st,
  output logic             sync_done,
  output logic             err_ack
);
  localparam logic [2:0] K_ARITH = 3'd0, K_SYNC = 3'd1, K_LD = 3'd2,
                         K_ST = 3'd3, K_PBS = 3'd4;
  localparam int NU = 3;  // unit index: 0 ARITH, 1 MEM, 2 PBS

  typedef enum logic [0:0] {ST_RUN, ST_DRAIN} state_t;

  // Every r with (r & mask) == (rid & mask).
  function automatic logic [RID_NB-1:0] dst_set(input logic [RID_W-1:0] rid,
                                                input logic [RID_W-1:0] mask);
    logic [RID_NB-1:0] s;
    for (int r = 0; r < RID_NB; r++)
      s[r] = ((RID_W'(r) & mask) == (rid & mask));
    return s;
  endfunction

  state_t               state_q, state_d;
  logic [RID_NB-1:0]    busy_q, busy_d, set_v, clr_v, dset;
  logic                 out_vld_q;
  logic [NU-1:0]        out_unit_q, tgt, hs_vec, occ_vec, cred_ok_vec, err_vec;
  logic [NU-1:0][3:0]   cred;
  logic                 err_q;
  logic                 is_ld, is_st, is_wr, is_issue, hazard, cred_ok, stage_free;
  logic                 hs, acc, iss;

  // Decode the presented instruction and evaluate hazards / resources.
  always_comb begin
    is_ld      = (in_kind == K_LD);
    is_st      = (in_kind == K_ST);
    is_wr      = (in_kind == K_ARITH) || is_ld || (in_kind == K_PBS);
    tgt        = {in_kind == K_PBS, is_ld || is_st, in_kind == K_ARITH};
    is_issue   = |tgt;
    dset       = dst_set(in_dst_rid, in_dst_mask);
    // MEM_LD's srca is a memory operand, ordered by the PEM queue itself.
    hazard     = (in_srca_vld && !is_ld && busy_q[in_srca_rid])
               | (in_srcb_vld && busy_q[in_srcb_rid])
               | (is_wr && |(busy_q & dset));
    hs_vec     = {pbs_rdy, mem_rdy, arith_rdy} & out_unit_q & {NU{out_vld_q}};
    occ_vec    = out_unit_q & {NU{out_vld_q}};
    hs         = |hs_vec;
    // An instruction parked in the output stage already owns a credit slot.
    for (int u = 0; u < NU; u++)
      cred_ok_vec[u] = ({1'b0, cred[u]} + {4'b0, occ_vec[u]}) < 5'(CRED_MAX);
    cred_ok    = |(tgt & cred_ok_vec);
    stage_free = !out_vld_q || hs;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_rdy    = 1'b0;
    sync_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_rdy = is_issue ? (!hazard && cred_ok && stage_free) : 1'b1;
        if (in_vld && in_rdy && in_kind == K_SYNC) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (busy_q == '0 && cred == '0 && !out_vld_q) begin
          sync_done = !s_rst;
          state_d   = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign acc = in_vld && in_rdy;
  assign iss = acc && is_issue;

  // Scoreboard: set on accepted writers, clear on acks from any unit.
  always_comb begin
    set_v  = (iss && is_wr) ? dset : '0;
    clr_v  = (arith_ack ? dst_set(arith_ack_rid, arith_ack_mask) : '0)
           | ((mem_ack && !mem_ack_st) ? dst_set(mem_ack_rid, mem_ack_mask) : '0)
           | (pbs_ack ? dst_set(pbs_ack_rid, pbs_ack_mask) : '0);
    busy_d = (busy_q & ~clr_v) | set_v;
  end

  // State, scoreboard and sticky error registers.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q <= ST_RUN;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_q | (|err_vec);
    end
  end

  // Output stage: load on issue, hold until the selected unit takes it.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      out_vld_q    <= 1'b0;
      out_unit_q   <= '0;
      out_kind     <= '0;
      out_dst_rid  <= '0;
      out_dst_mask <= '0;
      out_cid      <= '0;
      out_srca_rid <= '0;
      out_srcb_rid <= '0;
      out_flush    <= 1'b0;
    end else if (iss) begin
      out_vld_q    <= 1'b1;
      out_unit_q   <= tgt;
      out_kind     <= in_kind;
      out_dst_rid  <= in_dst_rid;
      out_dst_mask <= in_dst_mask;
      out_cid      <= in_cid;
      out_srca_rid <= in_srca_rid;
      out_srcb_rid <= in_srcb_rid;
      out_flush    <= in_flush;
    end else if (hs) begin
      out_vld_q    <= 1'b0;
    end
  end

  for (genvar g = 0; g < NU; g++) begin : g_cred
    logic ack_g;
    assign ack_g = (g == 0) ? arith_ack : (g == 1) ? mem_ack : pbs_ack;
    isc_cred_cnt u_cred (
      .clk   (clk),
      .s_rst (s_rst),
      .inc_i (hs_vec[g]),
      .dec_i (ack_g),
      .cnt_o (cred[g]),
      .err_o (err_vec[g])
    );
  end

  assign arith_vld = occ_vec[0];
  assign mem_vld   = occ_vec[1];
  assign pbs_vld   = occ_vec[2];
  assign err_ack   = err_q;
endmodule

// File: tb/tb_isc_issue_ctrl.sv
// Directed bench for isc_issue_ctrl: inputs driven and outputs sampled on
// the falling clock edge; expected values are hand-computed per scenario.
module tb_isc_issue_ctrl;
  logic        clk = 1'b0, s_rst;
  logic        in_vld, in_rdy, in_srca_vld, in_srcb_vld, in_flush;
  logic [2:0]  in_kind, out_kind;
  logic [5:0]  in_dst_rid, in_dst_mask, in_srca_rid, in_srcb_rid;
  logic [15:0] in_cid, out_cid;
  logic        arith_vld, mem_vld, pbs_vld, arith_rdy, mem_rdy, pbs_rdy;
  logic [5:0]  out_dst_rid, out_dst_mask, out_srca_rid, out_srcb_rid;
  logic        out_flush;
  logic        arith_ack, mem_ack, pbs_ack, mem_ack_st;
  logic [5:0]  arith_ack_rid, mem_ack_rid, pbs_ack_rid;
  logic [5:0]  arith_ack_mask, mem_ack_mask, pbs_ack_mask;
  logic        sync_done, err_ack;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  isc_issue_ctrl dut (
    .clk(clk), .s_rst(s_rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_kind(in_kind),
    .in_dst_rid(in_dst_rid), .in_dst_mask(in_dst_mask), .in_cid(in_cid),
    .in_srca_vld(in_srca_vld), .in_srca_rid(in_srca_rid),
    .in_srcb_vld(in_srcb_vld), .in_srcb_rid(in_srcb_rid), .in_flush(in_flush),
    .arith_vld(arith_vld), .mem_vld(mem_vld), .pbs_vld(pbs_vld),
    .arith_rdy(arith_rdy), .mem_rdy(mem_rdy), .pbs_rdy(pbs_rdy),
    .out_kind(out_kind), .out_dst_rid(out_dst_rid), .out_dst_mask(out_dst_mask),
    .out_cid(out_cid), .out_srca_rid(out_srca_rid), .out_srcb_rid(out_srcb_rid),
    .out_flush(out_flush), .arith_ack(arith_ack), .mem_ack(mem_ack), .pbs_ack(pbs_ack),
    .arith_ack_rid(arith_ack_rid), .mem_ack_rid(mem_ack_rid), .pbs_ack_rid(pbs_ack_rid),
    .arith_ack_mask(arith_ack_mask), .mem_ack_mask(mem_ack_mask),
    .pbs_ack_mask(pbs_ack_mask), .mem_ack_st(mem_ack_st),
    .sync_done(sync_done), .err_ack(err_ack)
  );

  task automatic idle();
    in_vld = 0; in_kind = 3'd0; in_dst_rid = 0; in_dst_mask = 6'h3F; in_cid = 0;
    in_srca_vld = 0; in_srca_rid = 0; in_srcb_vld = 0; in_srcb_rid = 0; in_flush = 0;
    arith_rdy = 1; mem_rdy = 1; pbs_rdy = 1;
    arith_ack = 0; mem_ack = 0; pbs_ack = 0; mem_ack_st = 0;
    arith_ack_rid = 0; mem_ack_rid = 0; pbs_ack_rid = 0;
    arith_ack_mask = 6'h3F; mem_ack_mask = 6'h3F; pbs_ack_mask = 6'h3F;
  endtask

  task automatic nxt();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); s_rst = 1;
    @(negedge clk); @(negedge clk); s_rst = 0;
  endtask

  task automatic put(input logic [2:0] k, input logic [5:0] dst, input logic [5:0] mask);
    idle(); in_vld = 1; in_kind = k; in_dst_rid = dst; in_dst_mask = mask;
  endtask

  task automatic test_reset();
    logic [43:0] got;
    @(negedge clk); idle(); in_vld = 1; s_rst = 1;
    #1;
    tests++;
    if (sync_done !== 1'b0) begin fails++; $display("FAIL reset_sync_in_rst: got %b want 0", sync_done); end
    @(negedge clk); @(negedge clk); s_rst = 0; in_vld = 0; #1;
    got = {arith_vld, mem_vld, pbs_vld, sync_done, err_ack, out_kind, out_dst_rid,
           out_dst_mask, out_cid, out_srca_rid, out_flush};
    tests++;
    if (got !== 44'h0) begin fails++; $display("FAIL reset_outputs: got %h want 0", got); end
    tests++;
    if (in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
  endtask

  task automatic test_raw();
    do_reset();
    put(3'd0, 6'd5, 6'h3F); #1;                         // c0
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL raw_first_rdy: got %b want 1", in_rdy); end
    nxt(); put(3'd0, 6'd6, 6'h3F); in_srca_vld = 1; in_srca_rid = 6'd5; #1;  // c1
    tests++; if ({arith_vld, out_dst_rid} !== {1'b1, 6'd5}) begin fails++; $display("FAIL raw_issue1: got %b/%0d want 1/5", arith_vld, out_dst_rid); end
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL raw_stall_c1: got %b want 0", in_rdy); end
    nxt();                                                // c2
    tests++; if ({in_rdy, arith_vld} !== 2'b00) begin fails++; $display("FAIL raw_stall_c2: got %b want 00", {in_rdy, arith_vld}); end
    nxt(); arith_ack = 1; arith_ack_rid = 6'd5; #1;       // c3 = T
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL raw_stall_T: got %b want 0", in_rdy); end
    nxt(); arith_ack = 0; #1;                             // T+1
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL raw_accept_T1: got %b want 1", in_rdy); end
    nxt(); in_vld = 0; #1;                                // T+2
    tests++; if ({arith_vld, out_dst_rid, out_srca_rid} !== {1'b1, 6'd6, 6'd5}) begin
      fails++; $display("FAIL raw_issue2: got %b/%0d/%0d want 1/6/5", arith_vld, out_dst_rid, out_srca_rid); end
  endtask

  task automatic test_mask();
    do_reset();
    put(3'd4, 6'd8, 6'h3C); #1;                           // c0 PBS 8..11
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL mask_pbs_rdy: got %b want 1", in_rdy); end
    nxt(); put(3'd3, 6'd0, 6'h3F); in_srca_vld = 1; in_srca_rid = 6'd10; in_cid = 16'd7; #1;  // c1
    tests++; if ({pbs_vld, out_dst_mask} !== {1'b1, 6'h3C}) begin fails++; $display("FAIL mask_pbs_out: got %b/%h want 1/3c", pbs_vld, out_dst_mask); end
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL mask_st_stall: got %b want 0", in_rdy); end
    nxt(); put(3'd2, 6'd12, 6'h3F); in_srca_vld = 1; in_srca_rid = 6'd10; #1;  // c2 LD
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL mask_ld_pass: got %b want 1", in_rdy); end
    nxt(); put(3'd3, 6'd0, 6'h3F); in_srca_vld = 1; in_srca_rid = 6'd10; in_cid = 16'd7;
    pbs_ack = 1; pbs_ack_rid = 6'd8; pbs_ack_mask = 6'h3C; #1;  // c3
    tests++; if ({mem_vld, out_kind, out_dst_rid} !== {1'b1, 3'd2, 6'd12}) begin
      fails++; $display("FAIL mask_ld_out: got %b/%0d/%0d want 1/2/12", mem_vld, out_kind, out_dst_rid); end
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL mask_st_ack_cycle: got %b want 0", in_rdy); end
    nxt(); pbs_ack = 0; #1;                               // c4
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL mask_st_release: got %b want 1", in_rdy); end
    nxt(); in_vld = 0; #1;                                // c5
    tests++; if ({mem_vld, out_kind, out_cid} !== {1'b1, 3'd3, 16'd7}) begin
      fails++; $display("FAIL mask_st_out: got %b/%0d/%0d want 1/3/7", mem_vld, out_kind, out_cid); end
  endtask

  task automatic test_sync();
    do_reset();
    for (int i = 1; i <= 3; i++) begin put(3'd0, 6'(i), 6'h3F); nxt(); end  // c0..c2
    put(3'd1, 6'd0, 6'h3F); #1;                           // c3 SYNC
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL sync_accept: got %b want 1", in_rdy); end
    for (int i = 1; i <= 3; i++) begin                    // c4..c6 acks
      nxt(); put(3'd0, 6'd4, 6'h3F); arith_ack = 1; arith_ack_rid = 6'(i); #1;
      tests++; if ({in_rdy, sync_done} !== 2'b00) begin fails++; $display("FAIL sync_drain_%0d: got %b want 00", i, {in_rdy, sync_done}); end
    end
    nxt(); arith_ack = 0; #1;                             // T+1
    tests++; if ({in_rdy, sync_done} !== 2'b01) begin fails++; $display("FAIL sync_done_pulse: got %b want 01", {in_rdy, sync_done}); end
    nxt();                                                // T+2
    tests++; if ({in_rdy, sync_done} !== 2'b10) begin fails++; $display("FAIL sync_resume: got %b want 10", {in_rdy, sync_done}); end
    nxt(); in_vld = 0; #1;
    tests++; if ({arith_vld, out_dst_rid} !== {1'b1, 6'd4}) begin fails++; $display("FAIL sync_post_issue: got %b/%0d want 1/4", arith_vld, out_dst_rid); end
  endtask

  task automatic test_credit();
    do_reset();
    for (int i = 0; i < 8; i++) begin                     // c0..c7
      put(3'd0, 6'(i), 6'h3F); #1;
      tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL cred_fill_%0d: got %b want 1", i, in_rdy); end
      nxt();
    end
    put(3'd0, 6'd8, 6'h3F); #1;                           // c8 eight in flight
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL cred_9th_c8: got %b want 0", in_rdy); end
    nxt();                                                // c9
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL cred_9th_c9: got %b want 0", in_rdy); end
    nxt(); arith_ack = 1; arith_ack_rid = 6'd0; #1;       // c10
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL cred_ack_cycle: got %b want 0", in_rdy); end
    nxt(); arith_ack = 0; #1;                             // c11
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL cred_after_ack: got %b want 1", in_rdy); end
    nxt(); put(3'd0, 6'd9, 6'h3F); arith_ack = 1; arith_ack_rid = 6'd1; #1;  // c12 hs + ack
    tests++; if ({arith_vld, in_rdy} !== 2'b10) begin fails++; $display("FAIL cred_hs_ack: got %b want 10", {arith_vld, in_rdy}); end
    nxt(); arith_ack = 0; #1;                             // c13 credit unchanged at 7
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL cred_hold: got %b want 1", in_rdy); end
    nxt(); put(3'd0, 6'd10, 6'h3F); nxt();                // c15 credit 8
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL cred_full_again: got %b want 0", in_rdy); end
  endtask

  task automatic test_stall();
    do_reset();
    put(3'd4, 6'd20, 6'h3F); in_flush = 1; in_srcb_vld = 1; in_srcb_rid = 6'd3;
    in_srca_rid = 6'd2; pbs_rdy = 0; nxt();               // c1
    for (int i = 1; i <= 5; i++) begin
      put(3'd0, 6'd21, 6'h3F); pbs_rdy = (i == 5); #1;
      tests++;
      if ({pbs_vld, arith_vld, out_flush, out_dst_rid, out_srca_rid, out_srcb_rid, out_kind} !==
          {1'b1, 1'b0, 1'b1, 6'd20, 6'd2, 6'd3, 3'd4}) begin
        fails++; $display("FAIL stall_hold_%0d: got %b%b%b/%0d/%0d/%0d/%0d want 101/20/2/3/4",
                          i, pbs_vld, arith_vld, out_flush, out_dst_rid, out_srca_rid, out_srcb_rid, out_kind);
      end
      tests++; if (in_rdy !== (i == 5)) begin fails++; $display("FAIL stall_rdy_%0d: got %b want %b", i, in_rdy, i == 5); end
      nxt();
    end
    in_vld = 0; #1;                                       // c6
    tests++; if ({arith_vld, pbs_vld, out_flush, out_dst_rid} !== {1'b1, 1'b0, 1'b0, 6'd21}) begin
      fails++; $display("FAIL stall_b2b: got %b%b%b/%0d want 100/21", arith_vld, pbs_vld, out_flush, out_dst_rid); end
  endtask

  task automatic test_illegal();
    do_reset();
    put(3'd7, 6'd5, 6'h3F); #1;
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL illegal_rdy: got %b want 1", in_rdy); end
    nxt(); put(3'd0, 6'd6, 6'h3F); in_srca_vld = 1; in_srca_rid = 6'd5; #1;
    tests++; if ({arith_vld, mem_vld, pbs_vld, in_rdy} !== 4'b0001) begin
      fails++; $display("FAIL illegal_drop: got %b want 0001", {arith_vld, mem_vld, pbs_vld, in_rdy}); end
  endtask

  task automatic test_err();
    do_reset();
    idle(); mem_ack = 1; #1;                              // c0
    nxt(); mem_ack = 0; #1;                               // c1
    tests++; if (err_ack !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", err_ack); end
    nxt(); put(3'd0, 6'd7, 6'h3F); #1;                    // c2
    tests++; if (err_ack !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err_ack); end
    nxt(); put(3'd1, 6'd0, 6'h3F); nxt(); idle(); #1;     // c4 DRAIN
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL err_drain_rdy: got %b want 0", in_rdy); end
    s_rst = 1; #1;
    tests++; if (sync_done !== 1'b0) begin fails++; $display("FAIL err_rst_sync: got %b want 0", sync_done); end
    nxt(); s_rst = 0; arith_ack = 1; arith_ack_rid = 6'd7; #1;  // c5
    tests++; if ({in_rdy, sync_done, err_ack, arith_vld, out_dst_rid, out_kind} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0}) begin
      fails++; $display("FAIL err_post_rst: got %b%b%b%b/%0d/%0d want 1000/0/0", in_rdy, sync_done, err_ack, arith_vld, out_dst_rid, out_kind); end
    nxt(); arith_ack = 0; #1;                             // c6
    tests++; if ({err_ack, sync_done} !== 2'b10) begin fails++; $display("FAIL err_late_ack: got %b want 10", {err_ack, sync_done}); end
  endtask

  initial begin
    idle(); s_rst = 1;
    test_reset();
    test_raw();
    test_mask();
    test_sync();
    test_credit();
    test_stall();
    test_illegal();
    test_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
